fc8_int_controller: RTL and testbench

Parametrised interrupt controller for the FC8 system; it replaces the fixed VBLANK-NMI/timer-IRQ logic in the SFR block. It latches up to NUM_SRC interrupt sources, each configurable as edge- or level-triggered, and masks them through INT_ENABLE. It routes selected sources to the CPU NMI line and the rest to the IRQ line, and reports the highest-priority pending IRQ index. An acknowledge handshake from the CPU auto-clears edge-triggered status bits.

---
 rtl/fc8_int_controller_pkg.sv | 33 +++
 rtl/fc8_prio_enc.sv | 28 ++
 rtl/fc8_int_controller.sv | 133 +++++++++++++
 tb/tb_fc8_int_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc8_int_controller_pkg.sv
// fc8_int_controller_pkg
// Shared definitions for the FC8 interrupt controller: register offsets,
// INT_VECTOR layout, reset constants and the vector formatting helper.
// No ports; imported by fc8_int_controller.
package fc8_int_controller_pkg;

  // Register map (2-bit offset).
  typedef enum logic [1:0] {
    REG_INT_ENABLE  = 2'd0,
    REG_INT_STATUS  = 2'd1,
    REG_INT_PENDING = 2'd2,
    REG_INT_VECTOR  = 2'd3
  } reg_off_e;

  // Bit position of the "vector valid" flag in INT_VECTOR.
  localparam int VEC_VALID_BIT = 7;

  // Value every register byte and the read-data register take out of reset.
  localparam logic [7:0] RST_BYTE = 8'h00;

  // INT_VECTOR byte: valid flag in bit 7, source index in bits [2:0],
  // all-zero when nothing is pending.
  function automatic logic [7:0] make_vector(input logic valid, input logic [2:0] idx);
    logic [7:0] v;
    v = RST_BYTE;
    if (valid) begin
      v[VEC_VALID_BIT] = 1'b1;
      v[2:0]           = idx;
    end
    return v;
  endfunction

endpackage

// File: rtl/fc8_prio_enc.sv
// fc8_prio_enc
// Purely combinational lowest-index priority encoder, shared with the DMA
// arbiter.
// Ports:
//   vec   in  NUM_SRC  request vector
//   valid out 1        any bit of vec set
//   idx   out 3        index of the lowest set bit (0 when none)
module fc8_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic               valid,
  output logic [2:0]         idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/fc8_int_controller.sv
// fc8_int_controller
// Interrupt controller: latches edge/level sources into INT_STATUS, masks
// with INT_ENABLE, routes to NMI or IRQ, reports the lowest pending IRQ index
// in INT_VECTOR and clears edge sources on the CPU acknowledge.
// Ports:
//   master_clk    in   1        clock
//   master_rst_n  in   1        synchronous active-low reset
//   src_in        in   NUM_SRC  raw interrupt requests
//   reg_addr      in   2        register offset
//   reg_wdata     in   8        write data
//   reg_we        in   1        write strobe
//   reg_re        in   1        read strobe
//   reg_rdata     out  8        registered read data (held between reads)
//   irq_ack       in   1        IRQ acknowledge pulse
//   cpu_irq_req   out  1        registered IRQ request
//   cpu_nmi_req   out  1        registered NMI request
module fc8_int_controller
  import fc8_int_controller_pkg::*;
#(
  parameter int         NUM_SRC      = 8,
  parameter logic [7:0] NMI_SRC_MASK = 8'h01,
  parameter logic [7:0] EDGE_MASK    = 8'hFF,
  parameter bit         AUTO_CLR     = 1'b1
) (
  input  logic               master_clk,
  input  logic               master_rst_n,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [1:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  input  logic               reg_we,
  input  logic               reg_re,
  output logic [7:0]         reg_rdata,
  input  logic               irq_ack,
  output logic               cpu_irq_req,
  output logic               cpu_nmi_req
);

  localparam logic [NUM_SRC-1:0] NMI_M  = NMI_SRC_MASK[NUM_SRC-1:0];
  localparam logic [NUM_SRC-1:0] EDGE_M = EDGE_MASK[NUM_SRC-1:0];

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] status_q, status_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] set_vec, w1c_vec, ack_vec;
  logic [NUM_SRC-1:0] pend, irq_pend, nmi_pend;
  logic [7:0]         rdata_q, rdata_d;
  logic               irq_q, nmi_q;
  logic               vec_valid;
  logic [2:0]         vec_idx;
  logic [7:0]         enable_b, status_b, pend_b;
  reg_off_e           addr;

  assign addr = reg_off_e'(reg_addr);

  // Per-source set condition, chosen at elaboration time.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_set
    if (EDGE_M[gi]) begin : g_edge
      assign set_vec[gi] = src_in[gi] & ~src_q[gi];
    end else begin : g_level
      assign set_vec[gi] = src_in[gi];
    end
  end

  assign pend     = status_q & enable_q;
  assign irq_pend = pend & ~NMI_M;
  assign nmi_pend = pend & NMI_M;

  fc8_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .vec   (irq_pend),
    .valid (vec_valid),
    .idx   (vec_idx)
  );

  // Ack only ever clears the source the CPU was actually vectored to, and
  // only if that source is edge-triggered (level sources need software).
  always_comb begin
    ack_vec = '0;
    if (AUTO_CLR && irq_ack && vec_valid && EDGE_M[vec_idx]) begin
      ack_vec[vec_idx] = 1'b1;
    end
  end

  assign w1c_vec = (reg_we && addr == REG_INT_STATUS) ? reg_wdata[NUM_SRC-1:0] : '0;

  // New sets are OR-ed in last so they beat same-cycle W1C and ack clears.
  assign status_d = (status_q & ~w1c_vec & ~ack_vec) | set_vec;
  assign enable_d = (reg_we && addr == REG_INT_ENABLE) ? reg_wdata[NUM_SRC-1:0] : enable_q;

  // Zero-extend to byte width so unimplemented bits read 0.
  always_comb begin
    enable_b = RST_BYTE;
    status_b = RST_BYTE;
    pend_b   = RST_BYTE;
    enable_b[NUM_SRC-1:0] = enable_q;
    status_b[NUM_SRC-1:0] = status_q;
    pend_b[NUM_SRC-1:0]   = pend;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (reg_re) begin
      case (addr)
        REG_INT_ENABLE:  rdata_d = enable_b;
        REG_INT_STATUS:  rdata_d = status_b;
        REG_INT_PENDING: rdata_d = pend_b;
        default:         rdata_d = make_vector(vec_valid, vec_idx);
      endcase
    end
  end

  always_ff @(posedge master_clk) begin
    if (!master_rst_n) begin
      src_q    <= '0;
      status_q <= '0;
      enable_q <= '0;
      rdata_q  <= RST_BYTE;
      irq_q    <= 1'b0;
      nmi_q    <= 1'b0;
    end else begin
      src_q    <= src_in;
      status_q <= status_d;
      enable_q <= enable_d;
      rdata_q  <= rdata_d;
      irq_q    <= |irq_pend;
      nmi_q    <= |nmi_pend;
    end
  end

  assign reg_rdata   = rdata_q;
  assign cpu_irq_req = irq_q;
  assign cpu_nmi_req = nmi_q;

endmodule

// File: tb/tb_fc8_int_controller.sv
// Testbench for fc8_int_controller (NUM_SRC=8, NMI mask 8'h01, source 3
// level-triggered, all others edge-triggered).
module tb_fc8_int_controller;

  localparam logic [7:0] NMI_M  = 8'h01;
  localparam logic [7:0] EDGE_M = 8'hF7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src_in;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we, reg_re, irq_ack;
  logic [7:0] reg_rdata;
  logic       cpu_irq_req, cpu_nmi_req;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fc8_int_controller #(
    .NUM_SRC(8), .NMI_SRC_MASK(NMI_M), .EDGE_MASK(EDGE_M), .AUTO_CLR(1'b1)
  ) dut (
    .master_clk(clk), .master_rst_n(rst_n), .src_in(src_in),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .irq_ack(irq_ack),
    .cpu_irq_req(cpu_irq_req), .cpu_nmi_req(cpu_nmi_req)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bits kept as per-source arrays; every rule applied directly at each edge.
  bit       m_status[8], m_enable[8], m_prev[8];
  bit       m_irq, m_nmi;
  bit [7:0] m_rdata;

  function automatic bit [7:0] pack(input bit a[8]);
    bit [7:0] r = 0;
    for (int i = 0; i < 8; i++) r[i] = a[i];
    return r;
  endfunction

  always @(posedge clk) begin
    bit       n_status[8];
    bit       any_irq, any_nmi, found, set_b, clr_b;
    int       first;
    bit [7:0] pend_b;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_status[i] = 0; m_enable[i] = 0; m_prev[i] = 0;
      end
      m_irq = 0; m_nmi = 0; m_rdata = 8'h00;
    end else begin
      any_irq = 0; any_nmi = 0; found = 0; first = 0; pend_b = 0;
      for (int i = 0; i < 8; i++) begin
        if (m_status[i] && m_enable[i]) begin
          pend_b[i] = 1;
          if (NMI_M[i]) any_nmi = 1;
          else begin
            any_irq = 1;
            if (!found) begin found = 1; first = i; end
          end
        end
      end
      if (reg_re) begin
        case (reg_addr)
          2'd0: m_rdata = pack(m_enable);
          2'd1: m_rdata = pack(m_status);
          2'd2: m_rdata = pend_b;
          default: m_rdata = found ? (8'h80 + 8'(first)) : 8'h00;
        endcase
      end
      for (int i = 0; i < 8; i++) begin
        set_b = EDGE_M[i] ? (src_in[i] && !m_prev[i]) : src_in[i];
        clr_b = (reg_we && reg_addr == 2'd1 && reg_wdata[i]) ||
                (irq_ack && found && first == i && EDGE_M[i]);
        n_status[i] = set_b ? 1'b1 : (clr_b ? 1'b0 : m_status[i]);
      end
      for (int i = 0; i < 8; i++) begin
        m_status[i] = n_status[i];
        m_prev[i]   = src_in[i];
        if (reg_we && reg_addr == 2'd0) m_enable[i] = reg_wdata[i];
      end
      m_irq = any_irq;
      m_nmi = any_nmi;
    end
  end

  // Cycle-by-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_irq",   {7'b0, cpu_irq_req}, {7'b0, m_irq});
      check("cyc_nmi",   {7'b0, cpu_nmi_req}, {7'b0, m_nmi});
      check("cyc_rdata", reg_rdata, m_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(negedge clk); endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    tick();
    reg_we = 1'b0;
    $display("WR addr=%0d data=%02h", a, d);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
    reg_addr = a; reg_re = 1'b1;
    tick();
    reg_re = 1'b0;
    $display("RD %s addr=%0d data=%02h", name, a, reg_rdata);
    check(name, reg_rdata, exp);
  endtask

  task automatic pulse(input logic [7:0] s);
    src_in = s;
    tick();
    src_in = 8'h00;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    $display("ACK");
  endtask

  initial begin
    rst_n = 1'b0; src_in = 0; reg_addr = 0; reg_wdata = 0;
    reg_we = 0; reg_re = 0; irq_ack = 0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_rdata", reg_rdata, 8'h00);
    check("rst_irq", {7'b0, cpu_irq_req}, 8'h00);
    rst_n = 1'b1;
    rd_chk("rst_enable", 2'd0, 8'h00);
    rd_chk("rst_status", 2'd1, 8'h00);

    // Basic IRQ
    wr(2'd0, 8'h06);
    pulse(8'h02);
    check("basic_irq_1edge", {7'b0, cpu_irq_req}, 8'h00);
    tick();
    check("basic_irq_2edge", {7'b0, cpu_irq_req}, 8'h01);
    rd_chk("basic_status", 2'd1, 8'h02);
    rd_chk("basic_vector", 2'd3, 8'h81);
    wr(2'd1, 8'h02);
    check("basic_clr_1edge", {7'b0, cpu_irq_req}, 8'h01);
    tick();
    check("basic_clr_2edge", {7'b0, cpu_irq_req}, 8'h00);

    // NMI routing
    wr(2'd0, 8'h01);
    pulse(8'h01);
    tick();
    check("nmi_req", {7'b0, cpu_nmi_req}, 8'h01);
    check("nmi_no_irq", {7'b0, cpu_irq_req}, 8'h00);
    rd_chk("nmi_vector", 2'd3, 8'h00);
    wr(2'd1, 8'h01);
    tick();
    check("nmi_clr", {7'b0, cpu_nmi_req}, 8'h00);

    // Priority and ack
    wr(2'd0, 8'hFE);
    pulse(8'h24);
    tick();
    rd_chk("prio_vector", 2'd3, 8'h82);
    ack();
    rd_chk("ack1_status", 2'd1, 8'h20);
    rd_chk("ack1_vector", 2'd3, 8'h85);
    ack();
    rd_chk("ack2_status", 2'd1, 8'h00);
    check("ack2_irq", {7'b0, cpu_irq_req}, 8'h00);

    // Masked latch (source 3 is level-triggered here)
    wr(2'd0, 8'h00);
    pulse(8'h08);
    tick();
    rd_chk("mask_status", 2'd1, 8'h08);
    rd_chk("mask_pending", 2'd2, 8'h00);
    check("mask_no_irq", {7'b0, cpu_irq_req}, 8'h00);
    wr(2'd0, 8'h08);
    tick();
    check("mask_en_irq", {7'b0, cpu_irq_req}, 8'h01);
    ack();
    rd_chk("ack_level_kept", 2'd1, 8'h08);
    wr(2'd1, 8'h08);
    rd_chk("level_sw_clr", 2'd1, 8'h00);

    // Level source held high: set beats W1C
    src_in = 8'h08;
    tick(); tick();
    wr(2'd1, 8'h08);
    rd_chk("level_conflict", 2'd1, 8'h08);
    src_in = 8'h00;
    tick();
    wr(2'd1, 8'h08);
    rd_chk("level_dropped", 2'd1, 8'h00);

    // Edge source held high: no re-set after W1C
    wr(2'd0, 8'h02);
    src_in = 8'h02;
    tick(); tick();
    wr(2'd1, 8'h02);
    rd_chk("edge_held_clr", 2'd1, 8'h00);
    src_in = 8'h00;
    tick(); tick();

    // Reset mid-operation, with an in-flight write
    wr(2'd0, 8'hFF);
    pulse(8'h02);
    tick();
    check("pre_rst_irq", {7'b0, cpu_irq_req}, 8'h01);
    src_in = 8'h10;
    rst_n = 1'b0;
    reg_addr = 2'd0; reg_wdata = 8'hFF; reg_we = 1'b1;
    tick();
    reg_we = 1'b0;
    check("midrst_irq", {7'b0, cpu_irq_req}, 8'h00);
    check("midrst_nmi", {7'b0, cpu_nmi_req}, 8'h00);
    check("midrst_rdata", reg_rdata, 8'h00);
    rst_n = 1'b1;
    tick();
    rd_chk("post_rst_status", 2'd1, 8'h10);
    rd_chk("post_rst_enable", 2'd0, 8'h00);
    rd_chk("post_rst_pending", 2'd2, 8'h00);
    src_in = 8'h00;
    tick(); tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
